lfsr_prbs_gen: RTL and testbench
================================

Name: lfsr_prbs_gen

Overview:
- Parametrised Fibonacci LFSR pseudo-random bit-sequence generator.
- Configurable width, tap mask and bits per cycle (STEP_W).
- Emits words over a valid/ready stream in bursts of a programmable length.
- Used as a test-pattern source and scrambler seed generator alongside the existing 8-bit LFSR primitives.

Parameters:
- WIDTH, 8: LFSR state width; legal range 3..64.
- TAPS, 8'h1D: feedback mask, WIDTH bits; bit k set means State[k] is XORed into the new MSB. The default implements x^8+x^6+x^5+x^4+1.
- RST_SEED, 8'h01: state after reset, WIDTH bits; must be non-zero.
- STEP_W, 1: LFSR shifts per accepted word, also the output word width; legal range 1..WIDTH.
- LEN_W, 16: width of the burst length input.
- CNT_W, 32: width of the emitted-word counter.

Ports:
- Clk_CI  in  1  clock, rising edge.
- Rst_RI  in  1  synchronous, active-high reset.
- Load_SI  in  1  load Seed_DI into the state; honoured in IDLE only.
- Seed_DI  in  WIDTH  seed value.
- Start_SI  in  1  start a burst; honoured in IDLE only.
- Len_DI  in  LEN_W  burst length in words, sampled with Start_SI.
- Stop_SI  in  1  abort the running burst.
- Dat_DO  out  STEP_W  output word; bit 0 is the earliest sequence bit.
- Vld_SO  out  1  Dat_DO is valid.
- Rdy_SI  in  1  downstream accepts Dat_DO.
- Busy_SO  out  1  FSM is in RUN.
- Done_SO  out  1  one-cycle pulse at burst end (normal or aborted).
- Cnt_DO  out  CNT_W  words accepted since the last reset or load.
- SeedErr_SO  out  1  one-cycle pulse: zero seed rejected.

Behaviour:
- Interface: one clock, Clk_CI. Reset Rst_RI is synchronous and active-high.
- Reset values: State=RST_SEED, FSM=IDLE, Vld_SO=0, Busy_SO=0, Done_SO=0, SeedErr_SO=0, Cnt_DO=0, remaining count=0.
- Single step: new MSB = XOR over k of (State[k] & TAPS[k]); all other bits take State[WIDTH-1:1]. This is a right shift.
- Output word: Dat_DO = State[STEP_W-1:0] (combinational from State); bit j is the bit output after j shifts.
- Word advance: on handshake (Vld_SO & Rdy_SI), State advances by exactly STEP_W single steps in one cycle (unrolled), Cnt_DO increments and wraps modulo 2^CNT_W, and the remaining count decrements.
- Back-pressure: with Vld_SO=1 and Rdy_SI=0, State and Dat_DO hold stable. Vld_SO never drops without a handshake, except on Stop_SI or reset.
- FSM IDLE:
  - Vld_SO=0.
  - Start_SI with Len_DI>0: go to RUN, remaining=Len_DI.
  - Start_SI with Len_DI=0: stay IDLE, pulse Done_SO next cycle.
  - Load_SI and Start_SI in the same cycle: the load takes effect first; the burst starts from the new seed.
- FSM RUN:
  - Vld_SO=1, Busy_SO=1.
  - Handshake with remaining=1: go to IDLE, pulse Done_SO in the following cycle.
  - Stop_SI: go to IDLE next cycle, Vld_SO drops, pulse Done_SO. A handshake in the same cycle still completes and is counted.
  - Load_SI and Start_SI are ignored.
- Load: State=Seed_DI and Cnt_DO=0 in the next cycle.
- Latency: Start_SI at cycle n gives Vld_SO=1 at cycle n+1.
- Reset mid-burst returns everything to reset values. No Done_SO pulse is generated.
- Period: with a primitive TAPS, State returns to the seed after (2^WIDTH-1) single steps.

Optional Feature:
- Macro: LFSR_ZERO_GUARD_EN.
- Defined: Load_SI with Seed_DI=0 loads RST_SEED instead and pulses SeedErr_SO for one cycle. Cnt_DO is still cleared.
- Undefined: a zero seed loads verbatim, the generator stays locked at 0 (Dat_DO=0 forever), and SeedErr_SO is tied to 0.

Decomposition:
- Package lfsr_pkg holds:
  - typedef enum {IDLE, RUN} lfsr_state_e;
  - constant DEFAULT_TAPS8=8'h1D;
  - constant DEFAULT_SEED8=8'h01;
  - function lfsr_step(state, taps), a single step parametrised by width.
- Sub-module lfsr_step_n is combinational: it applies STEP_W unrolled steps. It keeps the FSM, handshake and counters separate from the feedback network.

Test Plan:
- Default parameters, reset, Start with Len=6, Rdy=1 -> Dat_DO=1,0,0,0,0,0; State sequence 01,80,40,20,10,88; Done_SO pulses once; Cnt_DO=6.
- STEP_W=8, seed 0x01, Len=2, Rdy=1 -> words 0x01 then 0x71.
- Len=255, STEP_W=1, seed 0x01 -> after 255 handshakes State=0x01 again; no state repeats earlier.
- Rdy_SI toggles 1,0,0,1 during a burst -> Dat_DO stable while Rdy=0; Cnt_DO increments only on handshake cycles.
- Stop_SI asserted after 3 handshakes of a Len=10 burst -> Vld_SO=0 next cycle, Done_SO pulses, Cnt_DO=3.
- Load_SI with seed 0x00 -> with LFSR_ZERO_GUARD_EN: State=0x01 and SeedErr_SO pulse; without it: Dat_DO stays 0 over Len=4.

Source files
------------

// File: rtl/lfsr_prbs_gen_pkg.sv
// Shared types, defaults and the single-step feedback function for the LFSR PRBS generator.
package lfsr_pkg;

    typedef enum logic {IDLE, RUN} lfsr_state_e;

    localparam logic [7:0] DEFAULT_TAPS8 = 8'h1D;
    localparam logic [7:0] DEFAULT_SEED8 = 8'h01;
    localparam int         MAX_W         = 64;

    // Bits above `width` in state and taps must be zero.
    function automatic logic [MAX_W-1:0] lfsr_step(
        input logic [MAX_W-1:0] state,
        input logic [MAX_W-1:0] taps,
        input int               width
    );
        logic fb;
        fb = ^(state & taps);
        return (state >> 1) | ({{(MAX_W-1){1'b0}}, fb} << (width - 1));
    endfunction

endpackage

// File: rtl/lfsr_step_n.sv
// Combinational feedback network: STEP_W unrolled single LFSR steps.
module lfsr_step_n
    import lfsr_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] TAPS   = WIDTH'(DEFAULT_TAPS8),
    parameter int               STEP_W = 1
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] adv
);

    logic [STEP_W:0][WIDTH-1:0] chain;

    assign chain[0] = cur;

    for (genvar i = 0; i < STEP_W; i++) begin : g_step
        assign chain[i+1] = WIDTH'(lfsr_step(MAX_W'(chain[i]), MAX_W'(TAPS), WIDTH));
    end

    assign adv = chain[STEP_W];

endmodule

// File: rtl/lfsr_prbs_gen.sv
// Fibonacci LFSR PRBS source with burst control over a valid/ready stream.
// Optional zero-seed protection: LFSR_ZERO_GUARD_EN.
module lfsr_prbs_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(DEFAULT_TAPS8),
    parameter logic [WIDTH-1:0] RST_SEED = WIDTH'(DEFAULT_SEED8),
    parameter int               STEP_W   = 1,
    parameter int               LEN_W    = 16,
    parameter int               CNT_W    = 32
) (
    input  logic              Clk_CI,
    input  logic              Rst_RI,
    input  logic              Load_SI,
    input  logic [WIDTH-1:0]  Seed_DI,
    input  logic              Start_SI,
    input  logic [LEN_W-1:0]  Len_DI,
    input  logic              Stop_SI,
    output logic [STEP_W-1:0] Dat_DO,
    output logic              Vld_SO,
    input  logic              Rdy_SI,
    output logic              Busy_SO,
    output logic              Done_SO,
    output logic [CNT_W-1:0]  Cnt_DO,
    output logic              SeedErr_SO
);

    lfsr_state_e      fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d, state_adv, seed_sel;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             hs;

    lfsr_step_n #(
        .WIDTH  (WIDTH),
        .TAPS   (TAPS),
        .STEP_W (STEP_W)
    ) u_step (
        .cur (state_q),
        .adv (state_adv)
    );

`ifdef LFSR_ZERO_GUARD_EN
    logic err_q, err_d;
    assign seed_sel   = (Seed_DI == '0) ? RST_SEED : Seed_DI;
    assign SeedErr_SO = err_q;
`else
    assign seed_sel   = Seed_DI;
    assign SeedErr_SO = 1'b0;
`endif

    assign Vld_SO  = (fsm_q == RUN);
    assign Busy_SO = (fsm_q == RUN);
    assign Done_SO = done_q;
    assign Cnt_DO  = cnt_q;
    assign Dat_DO  = state_q[STEP_W-1:0];
    assign hs      = Vld_SO & Rdy_SI;

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef LFSR_ZERO_GUARD_EN
        err_d   = 1'b0;
`endif
        case (fsm_q)
            IDLE: begin
                // Load is applied to state_d first so a same-cycle Start runs from the new seed.
                if (Load_SI) begin
                    state_d = seed_sel;
                    cnt_d   = '0;
`ifdef LFSR_ZERO_GUARD_EN
                    err_d   = (Seed_DI == '0);
`endif
                end
                if (Start_SI) begin
                    if (Len_DI == '0) begin
                        done_d = 1'b1;
                    end else begin
                        fsm_d = RUN;
                        rem_d = Len_DI;
                    end
                end
            end
            RUN: begin
                if (hs) begin
                    state_d = state_adv;
                    cnt_d   = cnt_q + CNT_W'(1);
                    rem_d   = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        fsm_d  = IDLE;
                        done_d = 1'b1;
                    end
                end
                if (Stop_SI) begin
                    fsm_d  = IDLE;
                    done_d = 1'b1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            fsm_q   <= IDLE;
            state_q <= RST_SEED;
            rem_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
`ifdef LFSR_ZERO_GUARD_EN
            err_q   <= 1'b0;
`endif
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
`ifdef LFSR_ZERO_GUARD_EN
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Scoreboard bench for lfsr_prbs_gen: a 1-bit-per-word and an 8-bit-per-word instance share stimulus.
module tb_lfsr_prbs_gen;

    localparam logic [7:0] TAPS = 8'h1D;
    localparam logic [7:0] RSTS = 8'h01;
`ifdef LFSR_ZERO_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, load = 1'b0, start = 1'b0, stop = 1'b0, rdy = 1'b0;
    logic [7:0]  seed = '0;
    logic [15:0] len = '0;
    logic        dat1, vld1, busy1, done1, err1;
    logic [7:0]  dat8;
    logic        vld8, busy8, done8, err8;
    logic [31:0] cnt1, cnt8;

    always #5 clk = ~clk;

    lfsr_prbs_gen dut1 (
        .Clk_CI(clk), .Rst_RI(rst), .Load_SI(load), .Seed_DI(seed), .Start_SI(start),
        .Len_DI(len), .Stop_SI(stop), .Dat_DO(dat1), .Vld_SO(vld1), .Rdy_SI(rdy),
        .Busy_SO(busy1), .Done_SO(done1), .Cnt_DO(cnt1), .SeedErr_SO(err1)
    );

    lfsr_prbs_gen #(.STEP_W(8)) dut8 (
        .Clk_CI(clk), .Rst_RI(rst), .Load_SI(load), .Seed_DI(seed), .Start_SI(start),
        .Len_DI(len), .Stop_SI(stop), .Dat_DO(dat8), .Vld_SO(vld8), .Rdy_SI(rdy),
        .Busy_SO(busy8), .Done_SO(done8), .Cnt_DO(cnt8), .SeedErr_SO(err8)
    );

    typedef struct {
        logic        d1;
        logic [7:0]  d8;
        logic [7:0]  st1;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sbq[$];
    int          n_chk = 0, n_fail = 0;
    // Reference: the output bit stream obeys s[n+8] = XOR of s[n+k] over set tap bits k.
    bit          bits[8192];
    int          pos1 = 0, pos8 = 0;
    logic [31:0] mcnt = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] win(input int p);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[j] = bits[p+j];
        return r;
    endfunction

    task automatic model_load(input logic [7:0] s);
        logic [7:0] se;
        bit b;
        se = (GUARD && s == 8'h00) ? RSTS : s;
        for (int k = 0; k < 8; k++) bits[k] = se[k];
        for (int n = 8; n < 8192; n++) begin
            b = 1'b0;
            for (int k = 0; k < 8; k++) if (TAPS[k]) b ^= bits[n-8+k];
            bits[n] = b;
        end
        pos1 = 0;
        pos8 = 0;
        mcnt = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle the DUT shows a word, it must match the next scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && vld1) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_empty: got valid word %0h expected no word", dat8);
                end else begin
                    e = sbq.pop_front();
                    chk("dat1", dat1, e.d1);
                    chk("dat8", dat8, e.d8);
                    chk("state1", dut1.state_q, e.st1);
                    chk("cnt_live", cnt1, e.cnt);
                    chk("vld8", vld8, 1'b1);
                end
            end
        end
    end

    task automatic run_burst(input int l, input int stop_after, input bit do_load,
                             input logic [7:0] s, input bit rdy_all, input bit noise);
        int k = 0, cyc = 0;
        bit fin = 1'b0, r, st;
        start = 1'b1; len = 16'(l); load = do_load; seed = s; rdy = 1'b0;
        if (do_load) model_load(s);
        step();
        start = 1'b0; load = 1'b0;
        chk("seed_err", err1, do_load && GUARD && s == 8'h00);
        if (l == 0) begin
            chk("len0_vld", vld1, 1'b0);
            chk("len0_done", done1, 1'b1);
            step();
            chk("len0_done_end", done1, 1'b0);
            return;
        end
        chk("start_vld", vld1, 1'b1);
        chk("start_busy", busy1, 1'b1);
        while (!fin) begin
            st = (k == stop_after);
            r  = rdy_all ? !st : 1'($urandom_range(0, 1));
            if (cyc > 300) r = 1'b1;
            rdy = r; stop = st;
            if (noise && !st) begin
                load = ($urandom_range(0, 3) == 0);
                start = ($urandom_range(0, 3) == 0);
                seed = 8'($urandom);
                len = 16'($urandom);
            end
            sbq.push_back('{bits[pos1], win(pos8), win(pos1), mcnt});
            if (r) begin
                pos1++; pos8 += 8; mcnt++; k++;
            end
            if (st || k == l) fin = 1'b1;
            if (cyc > 400) begin
                chk("burst_bound", 1'b0, 1'b1);
                fin = 1'b1;
            end
            step();
            cyc++;
        end
        rdy = 1'b0; stop = 1'b0; load = 1'b0; start = 1'b0;
        chk("end_vld", vld1, 1'b0);
        chk("end_busy", busy1, 1'b0);
        chk("end_done", done1, 1'b1);
        chk("end_done8", done8, 1'b1);
        chk("end_cnt1", cnt1, mcnt);
        chk("end_cnt8", cnt8, mcnt);
        step();
        chk("done_pulse", done1, 1'b0);
        chk("err_idle", err8, 1'b0);
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        model_load(RSTS);
        chk("rst_vld", vld1, 1'b0);
        chk("rst_busy", busy8, 1'b0);
        chk("rst_done", done1, 1'b0);
        chk("rst_err", err1, 1'b0);
        chk("rst_cnt", cnt1, 32'd0);
        chk("rst_dat8", dat8, RSTS);
        chk("rst_dat1", dat1, 1'b1);

        run_burst(6, -1, 1'b0, 8'h00, 1'b1, 1'b0);
        run_burst(0, -1, 1'b0, 8'h00, 1'b1, 1'b0);
        run_burst(2, -1, 1'b1, 8'h01, 1'b1, 1'b0);
        run_burst(255, -1, 1'b1, 8'h01, 1'b1, 1'b0);
        chk("period_state1", dut1.state_q, 8'h01);
        chk("period_dat8", dat8, 8'h01);

        for (int i = 0; i < 8; i++) begin
            run_burst(int'($urandom_range(1, 20)),
                      ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 12)) : -1,
                      1'b1, 8'($urandom_range(1, 255)), 1'b0, 1'b1);
        end

        run_burst(10, 3, 1'b1, 8'h5A, 1'b1, 1'b0);
        chk("stop_cnt3", cnt1, 32'd3);

        run_burst(4, -1, 1'b1, 8'h00, 1'b1, 1'b0);
        chk("zero_seed_dat8", dat8, GUARD ? win(pos8) : 8'h00);

        // Reset in the middle of a burst.
        start = 1'b1; len = 16'd10; rdy = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rdy = 1'b1;
            sbq.push_back('{bits[pos1], win(pos8), win(pos1), mcnt});
            pos1++; pos8 += 8; mcnt++;
            step();
        end
        rdy = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        model_load(RSTS);
        chk("mid_rst_vld", vld1, 1'b0);
        chk("mid_rst_busy", busy1, 1'b0);
        chk("mid_rst_done", done1, 1'b0);
        chk("mid_rst_cnt", cnt1, 32'd0);
        chk("mid_rst_dat8", dat8, RSTS);
        step();
        chk("mid_rst_no_done", done1, 1'b0);

        run_burst(3, -1, 1'b0, 8'h00, 1'b1, 1'b0);

        repeat (3) step();
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
